// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO for ALU results.
// Each entry holds the result, the opcode that produced it, and the
// zero/carry/neg flags derived from the result when it is pushed.
// A result offered while the FIFO is full is dropped and raises a
// sticky drop_err. A synchronous clear flushes the FIFO and wins over
// any push or pop in the same cycle.
module alu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int RES_W = 17
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [RES_W-1:0]         in_result,
   input  logic [2:0]               in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [RES_W-1:0]         out_result,
   output logic [2:0]               out_op,
   output logic                     out_zero,
   output logic                     out_carry,
   output logic                     out_neg,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Entry storage (no reset needed)
   logic [RES_W-1:0] res_mem_q  [DEPTH];
   logic [2:0]       op_mem_q   [DEPTH];
   logic [2:0]       flag_mem_q [DEPTH];   // {zero, carry, neg}

   // Control state
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          drop_q,   drop_d;

   logic          push;
   logic          pop;
   logic [2:0]    in_flags;
   logic [2:0]    head_flags;

   // Handshake decode; clear suppresses both push and pop
   always_comb begin
      in_ready  = (count_q < FULL_CNT);
      out_valid = (count_q != '0);
      push      = in_valid && in_ready && !clear;
      pop       = out_valid && out_ready && !clear;
      in_flags  = {(in_result[RES_W-2:0] == '0), in_result[RES_W-1], in_result[RES_W-2]};
   end

   // Next-state for pointers, occupancy and the sticky drop flag
   always_comb begin
      // NOTE: every output of this block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         drop_d   = 1'b0;
      end else begin
         // Power-of-two depth: the increment wraps DEPTH-1 -> 0 naturally
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
         if (in_valid && !in_ready) drop_d = 1'b1;
      end
   end

   // Control registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Entry write on push
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; stale contents are never
      // visible because the outputs are gated by occupancy.
      if (push) begin
         res_mem_q[wr_ptr_q]  <= in_result;
         op_mem_q[wr_ptr_q]   <= in_op;
         flag_mem_q[wr_ptr_q] <= in_flags;
      end
   end

   // Head presentation straight from storage, zeroed when empty
   always_comb begin
      out_result = '0;
      out_op     = '0;
      head_flags = '0;
      if (out_valid) begin
         out_result = res_mem_q[rd_ptr_q];
         out_op     = op_mem_q[rd_ptr_q];
         head_flags = flag_mem_q[rd_ptr_q];
      end
      out_zero  = head_flags[2];
      out_carry = head_flags[1];
      out_neg   = head_flags[0];
      count     = count_q;
      drop_err  = drop_q;
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed testbench for alu_result_fifo with hand-computed expectations.
module tb_alu_result_fifo;

   localparam int DEPTH = 4;
   localparam int RES_W = 17;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [RES_W-1:0] in_result;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_result;
   logic [2:0]       out_op;
   logic             out_zero;
   logic             out_carry;
   logic             out_neg;
   logic [2:0]       count;
   logic             drop_err;

   int total = 0;
   int bad   = 0;

   alu_result_fifo #(.DEPTH(DEPTH), .RES_W(RES_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_op     (out_op),
      .out_zero   (out_zero),
      .out_carry  (out_carry),
      .out_neg    (out_neg),
      .count      (count),
      .drop_err   (drop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock edge, then settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [RES_W-1:0] r, input logic [2:0] op);
      in_valid  = 1'b1;
      in_result = r;
      in_op     = op;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [RES_W-1:0] r,
                             input logic z, input logic c, input logic n);
      check({tag, "_res"},   32'(out_result), 32'(r));
      check({tag, "_zero"},  32'(out_zero),   32'(z));
      check({tag, "_carry"}, 32'(out_carry),  32'(c));
      check({tag, "_neg"},   32'(out_neg),    32'(n));
   endtask

   logic [RES_W-1:0] fill_vals [4];
   logic [2:0]       fill_flags [4];
   logic [RES_W-1:0] model_q [$];

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_op     = '0;
      out_ready = 1'b0;

      // Reset state while rst_n low
      #3;
      check("rst_count",     32'(count),      32'd0);
      check("rst_out_valid", 32'(out_valid),  32'd0);
      check("rst_in_ready",  32'(in_ready),   32'd1);
      check("rst_drop",      32'(drop_err),   32'd0);
      check("rst_result",    32'(out_result), 32'd0);
      #9 rst_n = 1'b1;   // release between edges (t=12)

      // Single pass
      push(17'h00000, 3'd2);
      check("sp_valid", 32'(out_valid), 32'd1);
      check("sp_count", 32'(count),     32'd1);
      check("sp_op",    32'(out_op),    32'd2);
      check_head("sp", 17'h00000, 1'b1, 1'b0, 1'b0);
      pop();
      check("sp_pop_count", 32'(count),     32'd0);
      check("sp_pop_valid", 32'(out_valid), 32'd0);
      check("sp_empty_res", 32'(out_result), 32'd0);

      // Fill and overflow
      fill_vals[0] = 17'h1_8000; fill_flags[0] = 3'b011;
      fill_vals[1] = 17'h0_0001; fill_flags[1] = 3'b000;
      fill_vals[2] = 17'h0_7FFF; fill_flags[2] = 3'b000;
      fill_vals[3] = 17'h1_FFFF; fill_flags[3] = 3'b011;
      for (int i = 0; i < 4; i++) push(fill_vals[i], 3'(i));
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count",    32'(count),    32'd4);
      check("full_drop0",    32'(drop_err), 32'd0);
      push(17'h0_0005, 3'd7);
      check("ovf_drop",  32'(drop_err), 32'd1);
      check("ovf_count", 32'(count),    32'd4);
      for (int i = 0; i < 4; i++) begin
         check_head($sformatf("drain%0d", i), fill_vals[i],
                    fill_flags[i][2], fill_flags[i][1], fill_flags[i][0]);
         check($sformatf("drain%0d_op", i), 32'(out_op), 32'(i));
         pop();
      end
      check("drain_count", 32'(count),    32'd0);
      check("drain_drop",  32'(drop_err), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_drop", 32'(drop_err), 32'd0);

      // Simultaneous push/pop at count=2, crossing pointer wrap
      model_q.delete();
      push(17'h0_0100, 3'd1); model_q.push_back(17'h0_0100);
      push(17'h0_0101, 3'd1); model_q.push_back(17'h0_0101);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("pp%0d_head", i), 32'(out_result), 32'(model_q[0]));
         in_valid  = 1'b1;
         in_result = RES_W'(17'h0_0102 + i);
         in_op     = 3'd3;
         out_ready = 1'b1;
         tick();
         void'(model_q.pop_front());
         model_q.push_back(RES_W'(17'h0_0102 + i));
         check($sformatf("pp%0d_count", i), 32'(count), 32'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      while (model_q.size() > 0) begin
         check("pp_tail_head", 32'(out_result), 32'(model_q[0]));
         void'(model_q.pop_front());
         pop();
      end
      check("pp_empty", 32'(out_valid), 32'd0);

      // Clear with concurrent push at count=3
      push(17'h0_0011, 3'd0);
      push(17'h0_0012, 3'd0);
      push(17'h0_0013, 3'd0);
      check("cl_pre_count", 32'(count), 32'd3);
      in_valid  = 1'b1;
      in_result = 17'h0_0BAD;
      clear     = 1'b1;
      tick();
      in_valid  = 1'b0;
      clear     = 1'b0;
      check("cl_count", 32'(count),     32'd0);
      check("cl_drop",  32'(drop_err),  32'd0);
      check("cl_valid", 32'(out_valid), 32'd0);
      push(17'h0_0077, 3'd5);
      check("cl_after_count", 32'(count), 32'd1);
      check_head("cl_after", 17'h0_0077, 1'b0, 1'b0, 1'b0);
      pop();

      // Async reset mid-stream at count=3
      push(17'h1_0000, 3'd1);
      push(17'h0_0021, 3'd1);
      push(17'h0_0022, 3'd1);
      check("ar_pre_count", 32'(count), 32'd3);
      #2 rst_n = 1'b0;   // between edges
      #1;
      check("ar_count",    32'(count),      32'd0);
      check("ar_valid",    32'(out_valid),  32'd0);
      check("ar_in_ready", 32'(in_ready),   32'd1);
      check("ar_result",   32'(out_result), 32'd0);
      check("ar_op",       32'(out_op),     32'd0);
      check("ar_carry",    32'(out_carry),  32'd0);
      rst_n = 1'b1;
      push(17'h0_0042, 3'd6);
      check("ar_after_count", 32'(count),  32'd1);
      check("ar_after_op",    32'(out_op), 32'd6);
      check_head("ar_after", 17'h0_0042, 1'b0, 1'b0, 1'b0);
      pop();

      // Pop on empty for 3 cycles
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("pe%0d_count", i), 32'(count),     32'd0);
         check($sformatf("pe%0d_drop", i),  32'(drop_err),  32'd0);
         check($sformatf("pe%0d_valid", i), 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of result entries (power of two, at least 2).
REQ-002 The block SHALL have parameter RES_W, default 17, meaning the ALU result width, with the MSB as carry/borrow.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  ALU result offered this cycle.
REQ-006 in_ready  output  1  FIFO able to accept the offered result.
REQ-007 in_result  input  RES_W  ALU output value.
REQ-008 in_op  input  3  ALU operation selector that produced in_result.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_result  output  RES_W  head result.
REQ-012 out_op  output  3  head opcode.
REQ-013 out_zero / out_carry / out_neg  output  1 each  head flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 drop_err  output  1  sticky flag: a result was offered while full.
REQ-016 clear  input  1  synchronous flush.

Function
REQ-017 Push SHALL occur on a rising edge when in_valid=1 and in_ready=1.
REQ-018 Pop SHALL occur on a rising edge when out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL be asserted when count < DEPTH.
- No pass-through when full: a same-cycle pop does not raise in_ready.
REQ-020 out_valid SHALL be asserted when count != 0.
REQ-021 Ordering SHALL be first-word-fall-through: out_* shows the oldest stored entry combinationally from storage.
- No input-to-output bypass.
- A push into an empty FIFO becomes visible one cycle later.
REQ-022 Flags SHALL be computed at push time from in_result and stored with the entry:
- zero = (in_result[RES_W-2:0] == 0).
- carry = in_result[RES_W-1].
- neg = in_result[RES_W-2].
REQ-023 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
- When count=0, only the push takes effect.
REQ-024 Read and write pointers SHALL be modulo DEPTH and wrap from DEPTH-1 to 0 with no gap.
REQ-025 When in_valid=1 and in_ready=0, the result SHALL be discarded and drop_err set to 1.
- drop_err stays set until clear or reset.
REQ-026 When out_ready=1 and count=0, nothing SHALL happen and no error is raised.
REQ-027 clear=1 SHALL, on the next edge:
- set count and pointers to 0 and drop_err to 0.
- take priority over any push or pop in the same cycle (that push is lost and drop_err is not set).
REQ-028 While out_valid=0, out_result, out_op and the flags SHALL be 0.
REQ-029 Storage contents SHALL NOT require reset; only pointers, count and drop_err are reset.

Reset
REQ-030 While rst_n=0, regardless of clk:
- count=0, pointers=0, drop_err=0.
- out_valid=0, in_ready=1.
- out_result=0, out_op=0, flags=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries immediately.
- The first push after release SHALL land in slot 0.

Verification
REQ-032 Single pass: push result 17'h00000 with op=2.
- Next cycle: out_valid=1, out_zero=1, out_carry=0, count=1.
- Pop: count=0, out_valid=0.
REQ-033 Fill and overflow: push 17'h1_8000, 17'h0_0001, 17'h0_7FFF, 17'h1_FFFF, then push 17'h0_0005 while full.
- in_ready=0 after the fourth push and count=4.
- The fifth value is dropped and drop_err=1.
- Drain order is 1_8000 (carry=1, neg=1), 0_0001, 0_7FFF, 1_FFFF.
REQ-034 Simultaneous push/pop at count=2 for 8 cycles:
- count stays 2.
- Outputs stay in order across pointer wrap.
REQ-035 Clear with concurrent push at count=3:
- count=0, drop_err=0, out_valid=0 the next cycle.
- The pushed value never appears.
REQ-036 Async reset mid-stream at count=3, with rst_n pulsed low between clock edges:
- outputs go to reset values without a clock edge.
- After release, a push of 17'h0_0042 reads back as the head.
REQ-037 Pop on empty with out_ready held at 1 for 3 cycles:
- count stays 0, drop_err stays 0, out_valid stays 0.
